// File: rtl/shift_deser_pkg.sv
// Shared definitions for the shift_deser serial-to-parallel block.
// Holds data width, frame length, counter sizing and the FSM state type.
// Optional feature macro: SHIFT_DESER_PARITY_EN (adds an even-parity bit per frame).
package shift_deser_pkg;

   localparam int DATA_W = 4;

`ifdef SHIFT_DESER_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif

   localparam int CNT_W = 3;

   // Counter value of the bit that closes a frame.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   // Even parity: the parity bit equals the XOR of the data bits.
   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/deser_core.sv
// Bit-level receive engine: 4-bit shifter, frame bit counter and IDLE/RECV FSM.
// Ports: clk_i/rst_i; sin_i/sin_vld_i/sof_i in; done_o/word_o/par_err_o describe
// the frame closing this cycle (combinational, valid only while done_o is high).
// Optional feature macro: SHIFT_DESER_PARITY_EN (frame carries a trailing parity bit).
module deser_core
   import shift_deser_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sin_i,
   input  logic              sin_vld_i,
   input  logic              sof_i,
   output logic              done_o,
   output logic [DATA_W-1:0] word_o,
   output logic              par_err_o
);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;

   // Normal shift: MSB of the word arrives first, so new bits enter at bit 0.
   assign shift_d = {shift_q[DATA_W-2:0], sin_i};

   // A frame closes on a qualified bit at the last count. A bit arriving
   // together with sof is always bit 0 of a new frame, so it never closes one.
   assign done_o = sin_vld_i && !sof_i && (state_q == RECV) && (cnt_q == LAST_CNT);

`ifdef SHIFT_DESER_PARITY_EN
   // The closing bit is the parity bit; the data already sits in the shifter.
   assign word_o    = shift_q;
   assign par_err_o = even_par(shift_q) ^ sin_i;
`else
   // The closing bit is the data LSB; present the word as it will be shifted in.
   logic unused_msb;
   assign unused_msb = shift_q[DATA_W-1];
   assign word_o     = shift_d;
   assign par_err_o  = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (sof_i) begin
         // Realign: any partial frame is thrown away.
         if (sin_vld_i) begin
            state_q <= RECV;
            cnt_q   <= CNT_W'(1);
            shift_q <= {{(DATA_W-1){1'b0}}, sin_i};
         end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
         end
      end else if (sin_vld_i) begin
         shift_q <= shift_d;
         case (state_q)
            IDLE: begin
               state_q <= RECV;
               cnt_q   <= CNT_W'(1);
            end
            RECV: begin
               if (cnt_q == LAST_CNT) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_deser.sv
// Serial deserializer: turns an MSB-first bit stream into 4-bit words with a
// valid/ready output register, a sticky overrun flag and a sticky parity error.
// Ports: clk, rst (sync, active high); sin/sin_vld/sof in; dout/dout_vld/dout_rdy
// handshake; overrun/ovr_clr; parity_err. Word appears one cycle after its last bit.
// Optional feature macro: SHIFT_DESER_PARITY_EN (5-bit frames, parity_err live).
module shift_deser
   import shift_deser_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              sin_vld,
   input  logic              sof,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   input  logic              dout_rdy,
   output logic              overrun,
   input  logic              ovr_clr,
   output logic              parity_err
);

   logic              core_done;
   logic [DATA_W-1:0] core_word;
   logic              core_par_err;

   deser_core u_core (
      .clk_i     (clk),
      .rst_i     (rst),
      .sin_i     (sin),
      .sin_vld_i (sin_vld),
      .sof_i     (sof),
      .done_o    (core_done),
      .word_o    (core_word),
      .par_err_o (core_par_err)
   );

   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_vld_q, dout_vld_d;
   logic              overrun_q, overrun_d;
   logic              ovr_evt;

   // A completed word can only land if the slot is empty or being drained
   // this very cycle; otherwise it is dropped and recorded as an overrun.
   assign ovr_evt = core_done && dout_vld_q && !dout_rdy;

   always_comb begin
      dout_d     = dout_q;
      dout_vld_d = dout_vld_q;
      if (core_done && !ovr_evt) begin
         dout_d     = core_word;
         dout_vld_d = 1'b1;
      end else if (dout_vld_q && dout_rdy) begin
         dout_vld_d = 1'b0;
      end
   end

   // Set beats clear when both happen together.
   always_comb begin
      overrun_d = overrun_q;
      if (ovr_evt) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         overrun_q  <= overrun_d;
      end
   end

`ifdef SHIFT_DESER_PARITY_EN
   logic parity_err_q, parity_err_d;

   // Flags every failing frame, including ones dropped by an overrun.
   always_comb begin
      parity_err_d = parity_err_q;
      if (core_done && core_par_err) begin
         parity_err_d = 1'b1;
      end else if (ovr_clr) begin
         parity_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   logic unused_par;
   assign unused_par = core_par_err;
   assign parity_err = 1'b0;
`endif

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_shift_deser.sv
module tb_shift_deser;

`ifdef SHIFT_DESER_PARITY_EN
   localparam int NBITS = 5;
`else
   localparam int NBITS = 4;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sin = 1'b0;
   logic       sin_vld = 1'b0;
   logic       sof = 1'b0;
   logic       dout_rdy = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [3:0] dout;
   logic       dout_vld;
   logic       overrun;
   logic       parity_err;

   int nchk  = 0;
   int npass = 0;

   // Reference model state: bits of the frame in progress, plus output view.
   bit         m_bits[$];
   logic [3:0] m_dout;
   logic       m_vld;
   logic       m_ovr;
   logic       m_perr;

   shift_deser dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_vld    (sin_vld),
      .sof        (sof),
      .dout       (dout),
      .dout_vld   (dout_vld),
      .dout_rdy   (dout_rdy),
      .overrun    (overrun),
      .ovr_clr    (ovr_clr),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Apply the spec rules to the inputs of the coming clock edge.
   task automatic model_update();
      bit         done = 0;
      bit         bad  = 0;
      logic [3:0] w    = '0;
      bit         ovr_new = 0;
      if (rst) begin
         m_bits.delete();
         m_dout = 4'b0000; m_vld = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
         return;
      end
      if (sof) m_bits.delete();
      if (sin_vld) m_bits.push_back(sin);
      if (m_bits.size() == NBITS) begin
         done = 1;
         w = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
         if (NBITS == 5) bad = (m_bits[0] ^ m_bits[1] ^ m_bits[2] ^ m_bits[3] ^ m_bits[4]);
         m_bits.delete();
      end
      if (done) begin
         if (!m_vld || dout_rdy) begin
            m_dout = w;
            m_vld  = 1'b1;
         end else begin
            ovr_new = 1;
         end
      end else if (m_vld && dout_rdy) begin
         m_vld = 1'b0;
      end
      if (ovr_new) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      if (done && bad) m_perr = 1'b1;
      else if (ovr_clr) m_perr = 1'b0;
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
      chk("model_dout",   dout,              m_dout);
      chk("model_vld",    {3'b0, dout_vld},  {3'b0, m_vld});
      chk("model_ovr",    {3'b0, overrun},   {3'b0, m_ovr});
      chk("model_perr",   {3'b0, parity_err}, {3'b0, m_perr});
   endtask

   task automatic send_bit(input logic b);
      sin = b; sin_vld = 1'b1;
      tick();
      sin_vld = 1'b0; sin = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Sends a data word MSB first, plus its correct parity bit when enabled.
   task automatic send_word(input logic [3:0] w, input int gap);
      for (int i = 3; i >= 0; i--) begin
         send_bit(w[i]);
         if (gap > 0 && i > 0) idle(gap);
      end
`ifdef SHIFT_DESER_PARITY_EN
      send_bit(^w);
`endif
   endtask

   initial begin
      // Reset state
      sof = 1'b1; sin_vld = 1'b1; ovr_clr = 1'b1; sin = 1'b1;
      do_reset();
      sof = 1'b0; sin_vld = 1'b0; ovr_clr = 1'b0; sin = 1'b0;
      chk("rst_dout", dout, 4'b0000);
      chk("rst_vld",  {3'b0, dout_vld}, 4'h0);
      chk("rst_ovr",  {3'b0, overrun}, 4'h0);
      chk("rst_perr", {3'b0, parity_err}, 4'h0);

      // First word with the consumer stalled
      dout_rdy = 1'b0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      chk("w1_not_yet", {3'b0, dout_vld}, 4'h0);
      send_bit(1'b1);
`ifdef SHIFT_DESER_PARITY_EN
      chk("w1_par_pending", {3'b0, dout_vld}, 4'h0);
      send_bit(1'b1);
`endif
      chk("w1_dout", dout, 4'b1011);
      chk("w1_vld",  {3'b0, dout_vld}, 4'h1);
      idle(3);
      chk("w1_hold", dout, 4'b1011);

      // Drain, then a word spread across gaps
      dout_rdy = 1'b1; tick(); dout_rdy = 1'b0;
      chk("drain_vld", {3'b0, dout_vld}, 4'h0);
      send_word(4'b0110, 2);
      chk("gap_dout", dout, 4'b0110);
      chk("gap_ovr",  {3'b0, overrun}, 4'h0);

      // Overrun and clear
      do_reset();
      send_word(4'b1011, 0);
      send_word(4'b0001, 0);
      chk("ovr_dout", dout, 4'b1011);
      chk("ovr_set",  {3'b0, overrun}, 4'h1);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("ovr_clr",  {3'b0, overrun}, 4'h0);

      // Back-to-back with consumer always ready
      do_reset();
      dout_rdy = 1'b1;
      send_word(4'b1100, 0);
      chk("b2b_w1",     dout, 4'b1100);
      chk("b2b_w1_vld", {3'b0, dout_vld}, 4'h1);
      send_word(4'b0011, 0);
      chk("b2b_w2",     dout, 4'b0011);
      chk("b2b_w2_vld", {3'b0, dout_vld}, 4'h1);
      chk("b2b_ovr",    {3'b0, overrun}, 4'h0);
      dout_rdy = 1'b0;

      // Realignment with sof carrying bit 0
      do_reset();
      send_bit(1'b1); send_bit(1'b1);
      sof = 1'b1; send_bit(1'b0); sof = 1'b0;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifdef SHIFT_DESER_PARITY_EN
      send_bit(1'b0);
`endif
      chk("sof_dout", dout, 4'b0011);
      chk("sof_vld",  {3'b0, dout_vld}, 4'h1);

      // Reset mid-frame
      send_bit(1'b1); send_bit(1'b0);
      do_reset();
      chk("midrst_vld",  {3'b0, dout_vld}, 4'h0);
      chk("midrst_dout", dout, 4'b0000);
      send_word(4'b1001, 0);
      chk("midrst_word", dout, 4'b1001);

`ifdef SHIFT_DESER_PARITY_EN
      // Parity error and a clean frame
      do_reset();
      dout_rdy = 1'b1;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      chk("par_bad_err",  {3'b0, parity_err}, 4'h1);
      chk("par_bad_dout", dout, 4'b1011);
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      chk("par_ok_err",   {3'b0, parity_err}, 4'h0);
      chk("par_ok_dout",  dout, 4'b1011);
      dout_rdy = 1'b0;
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         sin      = 1'($urandom_range(0, 1));
         sin_vld  = ($urandom_range(0, 9) < 7);
         sof      = ($urandom_range(0, 19) == 0);
         dout_rdy = ($urandom_range(0, 1) == 1);
         ovr_clr  = ($urandom_range(0, 19) == 0);
         rst      = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0; sin_vld = 1'b0; sof = 1'b0; ovr_clr = 1'b0; dout_rdy = 1'b0;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
